tetris_cmd_gen: RTL and testbench

Command producer for the Tetris game core. It synchronizes and debounces the four raw player buttons and turns presses into `command_t` commands from `tetris_pkg`. Left, right and soft drop auto-repeat while held. Commands go to the game-logic consumer, one at a time, over a valid/ready handshake. It sits between the board's button pins (or MCU GPIO) and the game FSM, which consumes `command_t`.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/button_debounce.sv | 57 +++++
 rtl/tetris_cmd_gen.sv | 158 +++++++++++++++
 tb/tb_tetris_cmd_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the Tetris core: player commands, button indices and
// the auto-repeat state encoding used by the command producer.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_ROTATE    = 3'd3,
        CMD_SOFT_DROP = 3'd4
    } command_t;

    localparam int unsigned NUM_BTN       = 4;
    localparam int unsigned BTN_LEFT      = 0;
    localparam int unsigned BTN_RIGHT     = 1;
    localparam int unsigned BTN_ROTATE    = 2;
    localparam int unsigned BTN_SOFT_DROP = 3;

    // Buttons that auto-repeat while held (ROTATE is excluded).
    localparam logic [NUM_BTN-1:0] REPEAT_MASK = 4'b1011;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer, stable-count debounce and a
// one-cycle press pulse on the rising edge of the debounced level.
module button_debounce
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == TERM) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/tetris_cmd_gen.sv
// Turns debounced button presses (with DAS auto-repeat) into command_t
// offers on a valid/ready handshake, one pending bit per command.
module tetris_cmd_gen
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DAS_DELAY       = 8000000,
    parameter int unsigned REPEAT_PERIOD   = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output command_t           cmd,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int unsigned DAS_W = cnt_width(DAS_DELAY);
    localparam int unsigned REP_W = cnt_width(REPEAT_PERIOD);
    localparam int unsigned RCW   = (DAS_W > REP_W) ? DAS_W : REP_W;

    localparam logic [RCW-1:0] DAS_TERM = RCW'(DAS_DELAY - 1);
    localparam logic [RCW-1:0] REP_TERM = RCW'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[g]),
            .level(level[g]),
            .press(press[g])
        );
    end

    rpt_state_e         rpt_state_q [NUM_BTN];
    rpt_state_e         rpt_state_d [NUM_BTN];
    logic [RCW-1:0]     rpt_cnt_q   [NUM_BTN];
    logic [RCW-1:0]     rpt_cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_evt;

    always_comb begin
        rpt_evt = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            if (REPEAT_MASK[i]) begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (press[i]) begin
                            rpt_state_d[i] = RPT_DELAY;
                            rpt_cnt_d[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (!level[i]) begin
                            rpt_state_d[i] = RPT_IDLE;
                            rpt_cnt_d[i]   = '0;
                        end else if (rpt_cnt_q[i] == DAS_TERM) begin
                            rpt_evt[i]     = 1'b1;
                            rpt_state_d[i] = RPT_REPEAT;
                            rpt_cnt_d[i]   = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RCW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (!level[i]) begin
                            rpt_state_d[i] = RPT_IDLE;
                            rpt_cnt_d[i]   = '0;
                        end else if (rpt_cnt_q[i] == REP_TERM) begin
                            rpt_evt[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RCW'(1);
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end else begin
                rpt_state_d[i] = RPT_IDLE;
                rpt_cnt_d[i]   = '0;
            end
        end
    end

    logic [NUM_BTN-1:0] pend_q;
    logic [NUM_BTN-1:0] pend_d;
    logic [NUM_BTN-1:0] sel;
    command_t           cmd_q;
    command_t           cmd_d;
    logic               valid_q;
    logic               valid_d;
    logic               free;

    assign free = !valid_q || cmd_ready;

    // The issued bit is cleared before new events are OR-ed in, so an
    // event landing on the issue edge re-arms its bit instead of vanishing.
    always_comb begin
        sel     = '0;
        cmd_d   = cmd_q;
        valid_d = valid_q;
        if (free) begin
            valid_d = 1'b1;
            if (pend_q[BTN_ROTATE]) begin
                sel[BTN_ROTATE] = 1'b1;
                cmd_d           = CMD_ROTATE;
            end else if (pend_q[BTN_LEFT]) begin
                sel[BTN_LEFT] = 1'b1;
                cmd_d         = CMD_LEFT;
            end else if (pend_q[BTN_RIGHT]) begin
                sel[BTN_RIGHT] = 1'b1;
                cmd_d          = CMD_RIGHT;
            end else if (pend_q[BTN_SOFT_DROP]) begin
                sel[BTN_SOFT_DROP] = 1'b1;
                cmd_d              = CMD_SOFT_DROP;
            end else begin
                valid_d = 1'b0;
                cmd_d   = CMD_NONE;
            end
        end
        pend_d = (pend_q & ~sel) | press | rpt_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            cmd_q   <= CMD_NONE;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                rpt_cnt_q[i]   <= rpt_cnt_d[i];
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = valid_q;
    assign btn_level = level;

endmodule

// File: tb/tb_tetris_cmd_gen.sv
// Directed bench for tetris_cmd_gen: expected commands with their issue
// cycle are queued when buttons are driven and checked on acceptance.
module tb_tetris_cmd_gen;
    import tetris_pkg::*;

    localparam int unsigned DC  = 4;
    localparam int unsigned DAS = 20;
    localparam int unsigned RP  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    command_t   cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] btn_level;

    tetris_cmd_gen #(
        .DEBOUNCE_CYCLES(DC),
        .DAS_DELAY      (DAS),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        command_t    cmd;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_cmd(input int unsigned c, input command_t k);
        exp_t e;
        e.cyc = c;
        e.cmd = k;
        sb.push_back(e);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd), 32'(CMD_NONE));
        chk({tag, "_level"}, 32'(btn_level), 32'd0);
    endtask

    logic     prev_valid = 1'b0;
    logic     prev_ready = 1'b0;
    logic     prev_rst   = 1'b1;
    command_t prev_cmd   = CMD_NONE;

    always @(negedge clk) begin
        exp_t e;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            chk("cmd_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("cmd_value", 32'(cmd), 32'(e.cmd));
                chk("cmd_cycle", cyc, e.cyc);
            end
        end
        if (cmd_valid !== 1'b1) begin
            chk("idle_cmd_none", 32'(cmd), 32'(CMD_NONE));
        end
        if (prev_valid && !prev_ready && !prev_rst) begin
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_cmd", 32'(cmd), 32'(prev_cmd));
        end
        prev_valid = (cmd_valid === 1'b1);
        prev_ready = (cmd_ready === 1'b1);
        prev_rst   = (reset !== 1'b0);
        prev_cmd   = cmd;
    end

    initial begin
        int unsigned t0;
        int unsigned t1;

        reset     = 1'b1;
        btn_raw   = 4'b0000;
        cmd_ready = 1'b0;

        // Reset held for 3 cycles with buttons toggling.
        step(1);
        btn_raw = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            btn_raw = ~btn_raw;
            step(1);
            chk_reset_outputs("reset_hold");
        end
        reset   = 1'b0;
        btn_raw = 4'b0000;
        step(1);
        chk_reset_outputs("reset_after");
        step(10);

        // Single ROTATE press, held long: exactly one command.
        cmd_ready = 1'b1;
        btn_raw   = 4'b0100;
        t0        = cyc;
        expect_cmd(t0 + 8, CMD_ROTATE);
        step(5);
        chk("rot_level_pre", 32'(btn_level), 32'h0);
        step(1);
        chk("rot_level_rise", 32'(btn_level), 32'h4);
        step(94);
        chk("rot_sb_drained", 32'(sb.size()), 32'd0);
        btn_raw = 4'b0000;
        step(12);

        // Glitch shorter than the debounce window.
        btn_raw = 4'b0001;
        step(3);
        btn_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_level", 32'(btn_level), 32'h0);
        end

        // LEFT held through three repeats.
        btn_raw = 4'b0001;
        t0      = cyc;
        expect_cmd(t0 + 8,  CMD_LEFT);
        expect_cmd(t0 + 28, CMD_LEFT);
        expect_cmd(t0 + 36, CMD_LEFT);
        expect_cmd(t0 + 44, CMD_LEFT);
        step(42);
        btn_raw = 4'b0000;
        step(5);
        chk("left_level_held", 32'(btn_level), 32'h1);
        step(1);
        chk("left_level_fall", 32'(btn_level), 32'h0);
        step(14);
        chk("left_long_drained", 32'(sb.size()), 32'd0);

        // LEFT whose debounced release lands before the next repeat.
        btn_raw = 4'b0001;
        t0      = cyc;
        expect_cmd(t0 + 8,  CMD_LEFT);
        expect_cmd(t0 + 28, CMD_LEFT);
        expect_cmd(t0 + 36, CMD_LEFT);
        step(34);
        btn_raw = 4'b0000;
        step(30);
        chk("left_short_drained", 32'(sb.size()), 32'd0);

        // Backpressure, then priority drain back-to-back.
        cmd_ready = 1'b0;
        btn_raw   = 4'b1110;
        t0        = cyc;
        expect_cmd(t0 + 12, CMD_ROTATE);
        expect_cmd(t0 + 13, CMD_RIGHT);
        expect_cmd(t0 + 14, CMD_SOFT_DROP);
        step(7);
        chk("bp_valid_pre", 32'(cmd_valid), 32'd0);
        step(1);
        chk("bp_first_valid", 32'(cmd_valid), 32'd1);
        chk("bp_first_cmd", 32'(cmd), 32'(CMD_ROTATE));
        step(4);
        cmd_ready = 1'b1;
        step(3);
        chk("bp_drain_valid", 32'(cmd_valid), 32'd0);
        btn_raw = 4'b0000;
        step(30);
        chk("bp_sb_drained", 32'(sb.size()), 32'd0);

        // Reset while ROTATE is offered and LEFT pending; LEFT stays held.
        cmd_ready = 1'b0;
        btn_raw   = 4'b0101;
        step(8);
        chk("mid_valid", 32'(cmd_valid), 32'd1);
        chk("mid_cmd", 32'(cmd), 32'(CMD_ROTATE));
        reset   = 1'b1;
        btn_raw = 4'b0001;
        sb.delete();
        step(1);
        chk_reset_outputs("mid_reset1");
        step(1);
        chk_reset_outputs("mid_reset2");
        reset     = 1'b0;
        t1        = cyc;
        cmd_ready = 1'b1;
        expect_cmd(t1 + 8, CMD_LEFT);
        step(10);
        btn_raw = 4'b0000;
        step(20);
        chk("mid_sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
